div_ctrl_seq: RTL and testbench

Sequencing controller for the keypad calculator's divide path. Accepts a captured operand pair and runs the restoring divider on it. Runs the shared bin-to-BCD converter twice, once for the quotient and once for the remainder, and holds both BCD results for the 7-segment multiplexer. Flags divide-by-zero and, optionally, a stalled datapath. It sits between the operand capture stage and the divider, BCD converter and display.

---
 rtl/div_ctrl_seq.sv | 115 +++++++++++
 tb/tb_div_ctrl_seq.sv | 138 +++++++++++++
 2 files changed

// File: rtl/div_ctrl_seq.sv
// div_ctrl_seq: divide-path sequencer (divider -> two BCD conversions -> display hold).
// Optional watchdog enabled by defining DIV_CTRL_TIMEOUT_EN.
module div_ctrl_seq #(
   parameter int W = 7
`ifdef DIV_CTRL_TIMEOUT_EN
   , parameter int TIMEOUT = 255
`endif
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ops_valid,
   input  logic [W-1:0] a_in,
   input  logic [W-1:0] b_in,
   input  logic         show_toggle,
   output logic         div_start,
   output logic [W-1:0] div_a,
   output logic [W-1:0] div_b,
   input  logic         div_done,
   input  logic [W-1:0] div_q,
   input  logic [W-1:0] div_r,
   output logic         bcd_start,
   output logic [W-1:0] bcd_bin,
   input  logic         bcd_done,
   input  logic [15:0]  bcd_digits,
   output logic [15:0]  disp_digits,
   output logic         disp_sel,
   output logic         busy,
   output logic         result_valid,
   output logic         err,
   output logic [1:0]   err_code
);
   typedef enum logic [2:0] {IDLE, CHECK, DIV_RUN, BCD_Q, BCD_R, SHOW, ERR} state_t;
   state_t r_state;
   logic [W-1:0] r_rem;
   logic [15:0] r_q_bcd, r_r_bcd;
   logic w_wait, w_fire;
`ifdef DIV_CTRL_TIMEOUT_EN
   logic [7:0] r_wd;
`endif
   assign w_wait = r_state inside {DIV_RUN, BCD_Q, BCD_R};
   assign w_fire = (r_state == DIV_RUN && div_done) || (r_state inside {BCD_Q, BCD_R} && bcd_done);
   assign busy = w_wait || r_state == CHECK;
   assign err = r_state == ERR;
   assign disp_digits = r_state == SHOW ? (disp_sel ? r_r_bcd : r_q_bcd) :
                        r_state == ERR  ? {12'hEEE, 3'b000, err_code[1]} : 16'h0000;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state <= IDLE;
         div_start <= 1'b0;
         bcd_start <= 1'b0;
         result_valid <= 1'b0;
         div_a <= '0;
         div_b <= '0;
         bcd_bin <= '0;
         r_rem <= '0;
         r_q_bcd <= '0;
         r_r_bcd <= '0;
         disp_sel <= 1'b0;
         err_code <= 2'b00;
`ifdef DIV_CTRL_TIMEOUT_EN
         r_wd <= '0;
`endif
      end else begin
         div_start <= 1'b0;
         bcd_start <= 1'b0;
         result_valid <= 1'b0;
         case (r_state)
            IDLE, SHOW, ERR:
               if (ops_valid) begin
                  div_a <= a_in;
                  div_b <= b_in;
                  err_code <= 2'b00;
                  disp_sel <= 1'b0;
                  r_state <= CHECK;
               end else if (r_state == SHOW && show_toggle) disp_sel <= ~disp_sel;
            CHECK:
               if (div_b == '0) begin
                  err_code <= 2'b01;
                  r_state <= ERR;
               end else begin
                  div_start <= 1'b1;
                  r_state <= DIV_RUN;
               end
            DIV_RUN:
               if (div_done) begin
                  r_rem <= div_r;
                  bcd_bin <= div_q;
                  bcd_start <= 1'b1;
                  r_state <= BCD_Q;
               end
            BCD_Q:
               if (bcd_done) begin
                  r_q_bcd <= bcd_digits;
                  bcd_bin <= r_rem;
                  bcd_start <= 1'b1;
                  r_state <= BCD_R;
               end
            BCD_R:
               if (bcd_done) begin
                  r_r_bcd <= bcd_digits;
                  result_valid <= 1'b1;
                  r_state <= SHOW;
               end
            default: r_state <= IDLE;
         endcase
`ifdef DIV_CTRL_TIMEOUT_EN
         // Every wait state is entered through a start pulse, so clearing outside waits is equivalent.
         r_wd <= (w_wait && !w_fire) ? r_wd + 8'd1 : 8'd0;
         if (w_wait && !w_fire && r_wd == 8'(TIMEOUT - 1)) begin
            err_code <= 2'b10;
            r_state <= ERR;
         end
`endif
      end
endmodule

// File: tb/tb_div_ctrl_seq.sv
// tb_div_ctrl_seq: directed and random checks of div_ctrl_seq against arithmetic expectations.
module tb_div_ctrl_seq;
   logic clk = 0, rst = 1;
   logic ops_valid = 0, show_toggle = 0, div_done = 0, bcd_done = 0;
   logic [6:0] a_in = 0, b_in = 0, div_q = 0, div_r = 0;
   logic [15:0] bcd_digits = 0;
   logic div_start, bcd_start, disp_sel, busy, result_valid, err;
   logic [6:0] div_a, div_b, bcd_bin;
   logic [15:0] disp_digits;
   logic [1:0] err_code;
   int n_cmp = 0, n_bad = 0;

   div_ctrl_seq #(.W(7)
`ifdef DIV_CTRL_TIMEOUT_EN
      , .TIMEOUT(16)
`endif
   ) dut (.clk(clk), .rst(rst), .ops_valid(ops_valid), .a_in(a_in), .b_in(b_in),
      .show_toggle(show_toggle), .div_start(div_start), .div_a(div_a), .div_b(div_b),
      .div_done(div_done), .div_q(div_q), .div_r(div_r), .bcd_start(bcd_start),
      .bcd_bin(bcd_bin), .bcd_done(bcd_done), .bcd_digits(bcd_digits),
      .disp_digits(disp_digits), .disp_sel(disp_sel), .busy(busy),
      .result_valid(result_valid), .err(err), .err_code(err_code));

   always #5 clk = ~clk;

   function automatic logic [15:0] bcd(int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, {err, err_code}, 0);
      chk({tag, "_starts"}, {div_start, bcd_start, result_valid}, 0);
      chk({tag, "_data"}, {div_a, div_b, bcd_bin}, 0);
      chk({tag, "_disp"}, {disp_sel, disp_digits}, 0);
   endtask

   task automatic run_op(int a, int b, int dd, int bd, bit inject, bit abort_q);
      int q, r;
      q = (b == 0) ? 0 : a / b;
      r = (b == 0) ? 0 : a % b;
      @(negedge clk);
      ops_valid = 1; show_toggle = 1; a_in = 7'(a); b_in = 7'(b);
      @(negedge clk);
      ops_valid = 0; show_toggle = 0;
      chk("check_busy", busy, 1);
      chk("latched_ops", {div_a, div_b}, {7'(a), 7'(b)});
      chk("sel_cleared", disp_sel, 0);
      chk("no_early_start", div_start, 0);
      @(negedge clk);
      if (b == 0) begin
         chk("dz_err", {err, err_code}, 3'b101);
         chk("dz_disp", disp_digits, 16'hEEE0);
         chk("dz_idle", {busy, div_start}, 0);
         return;
      end
      chk("div_start", div_start, 1);
      for (int i = 0; i < dd; i++) begin
         if (inject && i == 0) begin ops_valid = 1; a_in = 9; b_in = 3; end
         @(negedge clk);
         ops_valid = 0;
      end
      chk("div_start_once", div_start, 0);
      chk("ops_held", {div_a, div_b}, {7'(a), 7'(b)});
      div_done = 1; div_q = 7'(q); div_r = 7'(r);
      @(negedge clk);
      div_done = 0; div_q = 0; div_r = 0;
      chk("bcd_start_q", {bcd_start, bcd_bin}, {1'b1, 7'(q)});
      if (abort_q) begin
         rst = 1;
         #1 chk_reset_outputs("abort");
         @(negedge clk);
         rst = 0;
         return;
      end
      repeat (bd) @(negedge clk);
      chk("bcd_hold_q", {bcd_start, bcd_bin}, {1'b0, 7'(q)});
      bcd_done = 1; bcd_digits = bcd(q);
      @(negedge clk);
      bcd_done = 0; bcd_digits = 0;
      chk("bcd_start_r", {bcd_start, bcd_bin}, {1'b1, 7'(r)});
      repeat (bd) @(negedge clk);
      bcd_done = 1; bcd_digits = bcd(r);
      @(negedge clk);
      bcd_done = 0; bcd_digits = 0;
      chk("result_valid", {result_valid, busy, err}, 3'b100);
      chk("disp_q", {disp_sel, disp_digits}, {1'b0, bcd(q)});
      @(negedge clk);
      chk("rv_once", result_valid, 0);
      show_toggle = 1;
      @(negedge clk);
      show_toggle = 0;
      chk("disp_r", {disp_sel, disp_digits}, {1'b1, bcd(r)});
      div_done = 1; bcd_done = 1; bcd_digits = 16'h9999;
      @(negedge clk);
      div_done = 0; bcd_done = 0; bcd_digits = 0;
      chk("stale_done", {result_valid, busy, bcd_start, disp_digits}, {3'b000, bcd(r)});
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 0;
      run_op(100, 7, 3, 2, 0, 0);
      run_op(5, 0, 1, 1, 0, 0);
      run_op(50, 5, 4, 1, 1, 0);
      run_op(9, 3, 1, 3, 0, 0);
      run_op(20, 3, 2, 2, 0, 1);
      run_op(8, 2, 2, 1, 0, 0);
      run_op(127, 1, 1, 1, 0, 0);
      for (int k = 0; k < 10; k++)
         run_op(int'($urandom_range(127)), int'($urandom_range(127)),
                int'($urandom_range(6, 1)), int'($urandom_range(4, 1)), 0, 0);
`ifdef DIV_CTRL_TIMEOUT_EN
      @(negedge clk);
      ops_valid = 1; a_in = 10; b_in = 3;
      @(negedge clk);
      ops_valid = 0;
      @(negedge clk);
      chk("to_div_start", div_start, 1);
      repeat (15) @(negedge clk);
      chk("to_not_yet", {busy, err}, 2'b10);
      @(negedge clk);
      chk("to_err", {busy, err, err_code}, 4'b0110);
      chk("to_disp", disp_digits, 16'hEEE1);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
